// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the four-digit multiplexed seven-segment driver.
//   state_t  - scan FSM states (IDLE / BLANK / SHOW)
//   SEG_OFF  - all segments dark (active-low)
//   AN_OFF   - all anodes off (active-low)
//   hex7()   - hex nibble to active-high {g,f,e,d,c,b,a} segment pattern
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_decode.sv
// seg7_decode: combinational hex-to-seven-segment decoder.
//   nibble  in  4  hex digit value
//   seg_hi  out 7  active-high {g,f,e,d,c,b,a}
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_hi
);

    always_comb begin
        seg_hi = hex7(nibble);
    end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed seven-segment display driver.
// Shows a 16-bit hex value, one digit per scan period, with an all-dark
// anti-ghosting window at the start of every digit slot. The value and the
// decimal points are captured once per frame so the display never tears.
//   clk         in   1   system clock
//   reset       in   1   asynchronous, active-high
//   scan_clk    in   1   scan strobe level (sampled, never used as a clock)
//   enable      in   1   1 = display running, 0 = all dark
//   data        in   16  hex value, digit i = data[4i+3:4i], digit 0 rightmost
//   dp_in       in   4   decimal point request per digit, active-high
//   blank_lz    in   1   1 = suppress leading zeros
//   an          out  4   digit anodes, active-low
//   seg         out  7   {g,f,e,d,c,b,a}, active-low
//   dp          out  1   decimal point, active-low
//   frame_done  out  1   one-cycle pulse when a new frame is latched
module seg7_scan
    import seg7_pkg::*;
#(
    parameter logic [15:0] BLANK_CYCLES = 16'd500,
    parameter int          DIGITS       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_clk,
    input  logic        enable,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [1:0] LAST_IDX = 2'(DIGITS - 1);

    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [15:0] bcnt, bcnt_n;
    logic [15:0] shadow, shadow_n;
    logic [3:0]  dpsh, dpsh_n;
    logic        scan_q;
    logic        scan_edge;
    logic        load;
    logic        fd_n;
    logic        lz_blank;
    logic [3:0]  nibble;
    logic [6:0]  seg_hi;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    // scan_clk already lives in the clk domain; a single register is enough
    // for edge detection.
    assign scan_edge = scan_clk & ~scan_q;

    // Next-state / bookkeeping
    always_comb begin
        state_n = state;
        idx_n   = idx;
        bcnt_n  = bcnt;
        load    = 1'b0;
        fd_n    = 1'b0;

        if (!enable) begin
            state_n = IDLE;
            idx_n   = '0;
            bcnt_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    idx_n = '0;
                    if (scan_edge) begin
                        load    = 1'b1;
                        fd_n    = 1'b1;
                        bcnt_n  = '0;
                        state_n = BLANK;
                    end
                end
                BLANK, SHOW: begin
                    if (scan_edge) begin
                        // Edge always opens a fresh blank window for the next
                        // digit, even if the current window is still running.
                        idx_n   = idx + 2'd1;
                        bcnt_n  = '0;
                        state_n = BLANK;
                        if (idx == LAST_IDX) begin
                            load = 1'b1;
                            fd_n = 1'b1;
                        end
                    end else if (state == BLANK) begin
                        // Zero-length window still costs one dark cycle.
                        if ((BLANK_CYCLES == 16'd0) || (bcnt == BLANK_CYCLES - 16'd1)) begin
                            state_n = SHOW;
                        end else begin
                            bcnt_n = bcnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = '0;
                    bcnt_n  = '0;
                end
            endcase
        end
    end

    assign shadow_n = load ? data  : shadow;
    assign dpsh_n   = load ? dp_in : dpsh;

    // Outputs are computed from the upcoming state so that the registered
    // outputs line up with the state register (one clk after the decision).
    always_comb begin
        nibble = '0;
        case (idx_n)
            2'd0: nibble = shadow_n[3:0];
            2'd1: nibble = shadow_n[7:4];
            2'd2: nibble = shadow_n[11:8];
            default: nibble = shadow_n[15:12];
        endcase
    end

    seg7_decode u_decode (
        .nibble (nibble),
        .seg_hi (seg_hi)
    );

    // Digit k is a leading zero when it and every more-significant nibble are 0.
    always_comb begin
        lz_blank = 1'b0;
        if (blank_lz) begin
            case (idx_n)
                2'd1:    lz_blank = (shadow_n[15:4]  == 12'd0);
                2'd2:    lz_blank = (shadow_n[15:8]  == 8'd0);
                2'd3:    lz_blank = (shadow_n[15:12] == 4'd0);
                default: lz_blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        an_n  = AN_OFF;
        seg_n = SEG_OFF;
        dp_n  = 1'b1;
        if ((state_n == SHOW) && !lz_blank) begin
            an_n  = ~(4'b0001 << idx_n);
            seg_n = ~seg_hi;
            dp_n  = ~dpsh_n[idx_n];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            bcnt       <= '0;
            shadow     <= '0;
            dpsh       <= '0;
            scan_q     <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            bcnt       <= bcnt_n;
            shadow     <= shadow_n;
            dpsh       <= dpsh_n;
            scan_q     <= scan_clk;
            an         <= an_n;
            seg        <= seg_n;
            dp         <= dp_n;
            frame_done <= fd_n;
        end
    end

endmodule
